// File: rtl/vc_lfdb_assembler.sv
// Line-fill buffer assembler: gathers DS_N downstream beats per entry into a cache line
// and presents completed lines one at a time, round-robin, to a single consumer.
module vc_lfdb_assembler #(
  parameter int BUS_WIDTH = 128,
  parameter int DS_N      = 4,
  parameter int ENTRY_NUM = 32,
  parameter int META_W    = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             alloc_req,
  input  logic [META_W-1:0]                alloc_meta,
  output logic                             alloc_gnt,
  output logic [$clog2(ENTRY_NUM)-1:0]     alloc_id,
  input  logic                             in_vld,
  input  logic [$clog2(ENTRY_NUM)-1:0]     in_entry_id,
  input  logic [BUS_WIDTH-1:0]             in_data,
  input  logic                             in_last,
  output logic                             out_vld,
  input  logic                             out_rdy,
  output logic [$clog2(ENTRY_NUM)-1:0]     out_entry_id,
  output logic [BUS_WIDTH*DS_N-1:0]        out_data,
  output logic [META_W-1:0]                out_meta,
  output logic [$clog2(ENTRY_NUM+1)-1:0]   free_cnt,
  output logic                             err_pulse
);
  localparam int IDW = $clog2(ENTRY_NUM);
  localparam int CW  = $clog2(ENTRY_NUM + 1);
  localparam int BCW = $clog2(DS_N);
  localparam int LW  = BUS_WIDTH * DS_N;

  typedef enum logic [1:0] {ST_FREE, ST_FILL, ST_FULL} st_e;

  st_e              st_q     [ENTRY_NUM];
  logic [BCW-1:0]   cnt_q    [ENTRY_NUM];
  logic [META_W-1:0] meta_q  [ENTRY_NUM];
  logic [LW-1:0]    line_q   [ENTRY_NUM];
  logic [IDW-1:0]   rr_ptr_q;
  logic [IDW-1:0]   hold_id_q;
  logic             hold_q;
  logic [CW-1:0]    free_cnt_q;
  logic             err_q;

  logic [IDW-1:0]   free_id;
  logic [IDW-1:0]   rr_id;
  logic [IDW-1:0]   sel_id;
  logic             any_full;
  logic             rel;
  logic             tgt_fill;
  logic             tgt_end;
  int               idx;

  always_comb begin
    free_id = '0;
    for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
      if (st_q[i] == ST_FREE) free_id = IDW'(i);
    end
  end

  // First FULL entry at or after rr_ptr, wrapping.
  always_comb begin
    rr_id    = '0;
    any_full = 1'b0;
    idx      = 0;
    for (int k = 0; k < ENTRY_NUM; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= ENTRY_NUM) idx = idx - ENTRY_NUM;
      if (!any_full && st_q[idx] == ST_FULL) begin
        any_full = 1'b1;
        rr_id    = IDW'(idx);
      end
    end
  end

  always_comb begin
    tgt_fill = 1'b0;
    tgt_end  = 1'b0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      if (in_entry_id == IDW'(i)) begin
        tgt_fill = (st_q[i] == ST_FILL);
        tgt_end  = (cnt_q[i] == BCW'(DS_N - 1));
      end
    end
  end

  // A presented-but-stalled line is pinned so later completions cannot preempt it.
  assign sel_id    = hold_q ? hold_id_q : rr_id;
  assign rel       = any_full && out_rdy;
  assign alloc_gnt = alloc_req && (free_cnt_q != '0);
  assign alloc_id  = free_id;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
        st_q[i]  <= ST_FREE;
        cnt_q[i] <= '0;
      end
      rr_ptr_q   <= '0;
      hold_q     <= 1'b0;
      hold_id_q  <= '0;
      free_cnt_q <= CW'(ENTRY_NUM);
      err_q      <= 1'b0;
    end else begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
        if (in_vld && in_entry_id == IDW'(i) && st_q[i] == ST_FILL) begin
          cnt_q[i] <= cnt_q[i] + BCW'(1);
          if (in_last || cnt_q[i] == BCW'(DS_N - 1)) st_q[i] <= ST_FULL;
        end
        if (rel && sel_id == IDW'(i)) st_q[i] <= ST_FREE;
        if (alloc_gnt && alloc_id == IDW'(i)) begin
          st_q[i]  <= ST_FILL;
          cnt_q[i] <= '0;
        end
      end
      if (rel) rr_ptr_q <= (sel_id == IDW'(ENTRY_NUM - 1)) ? '0 : sel_id + IDW'(1);
      hold_q     <= any_full && !out_rdy;
      hold_id_q  <= sel_id;
      free_cnt_q <= free_cnt_q + CW'(rel) - CW'(alloc_gnt);
      err_q      <= in_vld && (!tgt_fill || (in_last != tgt_end));
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < ENTRY_NUM; i++) begin
      if (in_vld && in_entry_id == IDW'(i) && st_q[i] == ST_FILL)
        line_q[i][int'(cnt_q[i])*BUS_WIDTH +: BUS_WIDTH] <= in_data;
      if (alloc_gnt && alloc_id == IDW'(i)) meta_q[i] <= alloc_meta;
    end
  end

  assign out_vld      = any_full;
  assign out_entry_id = sel_id;
  assign out_data     = line_q[sel_id];
  assign out_meta     = meta_q[sel_id];
  assign free_cnt     = free_cnt_q;
  assign err_pulse    = err_q;

endmodule

// File: tb/tb_vc_lfdb_assembler.sv
// Bench for vc_lfdb_assembler: directed scenarios then random traffic, all checked by a
// queue-based scoreboard fed from an abstract per-entry model of the line-fill buffer.
module tb_vc_lfdb_assembler;
  localparam int BW  = 128;
  localparam int DSN = 4;
  localparam int EN  = 32;
  localparam int MW  = 16;
  localparam int LW  = BW * DSN;
  localparam int IDW = $clog2(EN);
  localparam int CW  = $clog2(EN + 1);
  localparam int S_FREE = 0, S_FILL = 1, S_FULL = 2;

  logic            clk;
  logic            rst;
  logic            alloc_req;
  logic [MW-1:0]   alloc_meta;
  logic            alloc_gnt;
  logic [IDW-1:0]  alloc_id;
  logic            in_vld;
  logic [IDW-1:0]  in_entry_id;
  logic [BW-1:0]   in_data;
  logic            in_last;
  logic            out_vld;
  logic            out_rdy;
  logic [IDW-1:0]  out_entry_id;
  logic [LW-1:0]   out_data;
  logic [MW-1:0]   out_meta;
  logic [CW-1:0]   free_cnt;
  logic            err_pulse;

  vc_lfdb_assembler #(.BUS_WIDTH(BW), .DS_N(DSN), .ENTRY_NUM(EN), .META_W(MW)) dut (
    .clk(clk), .rst(rst),
    .alloc_req(alloc_req), .alloc_meta(alloc_meta), .alloc_gnt(alloc_gnt), .alloc_id(alloc_id),
    .in_vld(in_vld), .in_entry_id(in_entry_id), .in_data(in_data), .in_last(in_last),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_entry_id(out_entry_id),
    .out_data(out_data), .out_meta(out_meta), .free_cnt(free_cnt), .err_pulse(err_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { bit chk; bit gnt; int id; int free; bit vld; int sel; bit err; } exp_t;
  typedef struct { int id; logic [LW-1:0] data; logic [DSN-1:0] known; logic [MW-1:0] meta; } line_t;

  exp_t  exp_q[$];
  line_t line_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  int             m_st    [EN];
  int             m_cnt   [EN];
  logic [MW-1:0]  m_meta  [EN];
  logic [LW-1:0]  m_line  [EN];
  logic [DSN-1:0] m_known [EN];
  int m_rr, m_hold_id;
  bit m_err, m_hold, m_init;

  task automatic chk(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp_v);
    end
  endtask

  task automatic chk_line(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp_v);
    end
  endtask

  // Model: predict this cycle's outputs, then apply the cycle's inputs to the entry table.
  task automatic model_cycle();
    exp_t e;
    line_t l;
    int nfree, lowest, sel, t;
    bit err_n;
    nfree = 0; lowest = -1; sel = -1;
    for (int i = 0; i < EN; i++)
      if (m_st[i] == S_FREE) begin
        nfree++;
        if (lowest < 0) lowest = i;
      end
    if (m_hold) sel = m_hold_id;
    else
      for (int k = 0; k < EN; k++)
        if (sel < 0 && m_st[(m_rr + k) % EN] == S_FULL) sel = (m_rr + k) % EN;
    e.chk = m_init; e.gnt = alloc_req && nfree > 0; e.id = lowest; e.free = nfree;
    e.vld = sel >= 0; e.sel = sel; e.err = m_err;
    exp_q.push_back(e);
    if (rst) begin
      for (int i = 0; i < EN; i++) begin m_st[i] = S_FREE; m_cnt[i] = 0; end
      m_rr = 0; m_err = 0; m_hold = 0; m_init = 1;
      return;
    end
    err_n = 0;
    if (in_vld) begin
      t = int'(in_entry_id);
      if (m_st[t] == S_FILL) begin
        m_line[t][m_cnt[t]*BW +: BW] = in_data;
        m_known[t][m_cnt[t]] = 1'b1;
        if (in_last != (m_cnt[t] == DSN - 1)) err_n = 1;
        if (in_last || m_cnt[t] == DSN - 1) m_st[t] = S_FULL;
        m_cnt[t]++;
      end else err_n = 1;
    end
    m_hold = e.vld && !out_rdy;
    m_hold_id = sel;
    if (e.vld && out_rdy) begin
      l.id = sel; l.data = m_line[sel]; l.known = m_known[sel]; l.meta = m_meta[sel];
      line_q.push_back(l);
      m_st[sel] = S_FREE;
      m_rr = (sel + 1) % EN;
    end
    if (e.gnt) begin
      m_st[lowest] = S_FILL; m_cnt[lowest] = 0; m_meta[lowest] = alloc_meta;
    end
    m_err = err_n;
  endtask

  always @(negedge clk) begin
    exp_t e;
    line_t l;
    logic [LW-1:0] mask;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.chk) begin
        chk("sb_gnt", int'(alloc_gnt), int'(e.gnt));
        chk("sb_free", int'(free_cnt), e.free);
        chk("sb_vld", int'(out_vld), int'(e.vld));
        chk("sb_err", int'(err_pulse), int'(e.err));
        if (e.gnt) chk("sb_alloc_id", int'(alloc_id), e.id);
        if (e.vld) chk("sb_out_id", int'(out_entry_id), e.sel);
      end
    end
    if (!rst && out_vld && out_rdy) begin
      if (line_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL sb_line_unexpected actual=id %0d required=no line", out_entry_id);
      end else begin
        l = line_q.pop_front();
        mask = '0;
        for (int s = 0; s < DSN; s++) if (l.known[s]) mask[s*BW +: BW] = '1;
        chk("sb_line_id", int'(out_entry_id), l.id);
        chk("sb_line_meta", int'(out_meta), int'(l.meta));
        chk_line("sb_line_data", out_data & mask, l.data & mask);
      end
    end
  end

  task automatic drive(input bit r, input bit req, input logic [MW-1:0] meta, input bit v,
                       input int id, input logic [BW-1:0] d, input bit last, input bit rdy);
    rst = r; alloc_req = req; alloc_meta = meta; in_vld = v;
    in_entry_id = IDW'(id); in_data = d; in_last = last; out_rdy = rdy;
    model_cycle();
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit rdy);
    drive(0, 0, '0, 0, 0, '0, 0, rdy);
  endtask

  task automatic beat(input int id, input logic [BW-1:0] d, input bit last);
    drive(0, 0, '0, 1, id, d, last, 0);
    tick();
  endtask

  task automatic fill(input int id, input int base);
    for (int b = 0; b < DSN; b++) beat(id, BW'(base + b), b == DSN - 1);
  endtask

  initial begin
    logic [LW-1:0] exp_line;
    for (int i = 0; i < EN; i++) begin m_st[i] = S_FREE; m_cnt[i] = 0; m_known[i] = '0; end
    m_rr = 0; m_err = 0; m_hold = 0; m_init = 0; m_hold_id = 0;
    rst = 1; alloc_req = 0; alloc_meta = '0; in_vld = 0; in_entry_id = '0;
    in_data = '0; in_last = 0; out_rdy = 0;
    @(posedge clk); #1;
    drive(1, 0, '0, 0, 0, '0, 0, 0); tick();
    drive(1, 0, '0, 0, 0, '0, 0, 0); tick();

    // Basic fill of entry 0
    drive(0, 1, 16'h00AA, 0, 0, '0, 0, 0);
    chk("rst_free", int'(free_cnt), EN);
    chk("rst_vld", int'(out_vld), 0);
    chk("rst_err", int'(err_pulse), 0);
    chk("rst_gnt", int'(alloc_gnt), 1);
    chk("alloc_id0", int'(alloc_id), 0);
    tick();
    for (int b = 1; b <= DSN; b++) beat(0, BW'(b), b == DSN);
    idle(1);
    exp_line = {128'h4, 128'h3, 128'h2, 128'h1};
    chk("basic_vld", int'(out_vld), 1);
    chk("basic_id", int'(out_entry_id), 0);
    chk_line("basic_data", out_data, exp_line);
    chk("basic_meta", int'(out_meta), 'hAA);
    chk("basic_err", int'(err_pulse), 0);
    tick();

    // Early last, then a beat to a FREE entry
    drive(0, 1, 16'h00BB, 0, 0, '0, 0, 0);
    chk("realloc_id0", int'(alloc_id), 0);
    tick();
    beat(0, 128'h11, 0);
    beat(0, 128'h12, 1);
    drive(0, 0, '0, 1, 5, 128'h55, 0, 0);
    chk("early_last_err", int'(err_pulse), 1);
    chk("early_last_vld", int'(out_vld), 1);
    tick();
    idle(0);
    chk("bad_tgt_err", int'(err_pulse), 1);
    chk("bad_tgt_free", int'(free_cnt), EN - 1);
    tick();
    idle(1);
    chk("err_one_cycle", int'(err_pulse), 0);
    exp_line = {128'h4, 128'h3, 128'h12, 128'h11};
    chk_line("early_last_data", out_data, exp_line);
    tick();

    // Fill the buffer completely, then free entry 7
    for (int i = 0; i < EN; i++) begin
      drive(0, 1, MW'(i), 0, 0, '0, 0, 0);
      chk("full_id", int'(alloc_id), i);
      chk("full_free", int'(free_cnt), EN - i);
      tick();
    end
    drive(0, 1, 16'h0033, 0, 0, '0, 0, 0);
    chk("full_nogrant", int'(alloc_gnt), 0);
    chk("full_free0", int'(free_cnt), 0);
    tick();
    fill(7, 'h70);
    drive(0, 1, 16'h0077, 0, 0, '0, 0, 1);
    chk("rel7_id", int'(out_entry_id), 7);
    chk("rel7_no_bypass", int'(alloc_gnt), 0);
    tick();
    drive(0, 1, 16'h007E, 0, 0, '0, 0, 0);
    chk("rel7_free1", int'(free_cnt), 1);
    chk("regrant_id7", int'(alloc_id), 7);
    tick();

    // Round-robin: release 9 to put rr_ptr at 10, then complete 20, 2, 9
    fill(9, 'h90);
    idle(1);
    chk("rel9_id", int'(out_entry_id), 9);
    tick();
    drive(0, 1, 16'h0099, 0, 0, '0, 0, 0);
    chk("regrant_id9", int'(alloc_id), 9);
    tick();
    fill(20, 'h200);
    fill(2, 'h20);
    fill(9, 'h900);
    for (int c = 0; c < 3; c++) begin
      idle(0);
      chk("rr_hold20", int'(out_entry_id), 20);
      tick();
    end
    idle(1); chk("drain0", int'(out_entry_id), 20); tick();
    idle(1); chk("drain1", int'(out_entry_id), 2); tick();
    idle(1); chk("drain2", int'(out_entry_id), 9); tick();

    // Grant + release + beat to another entry in one cycle, then reset mid-fill
    fill(7, 'h700);
    drive(0, 1, 16'h0CCC, 1, 1, 128'hB1, 0, 1);
    chk("gr_rel_id", int'(out_entry_id), 7);
    chk("gr_rel_gnt_id", int'(alloc_id), 2);
    chk("gr_rel_free_before", int'(free_cnt), 3);
    tick();
    idle(0);
    chk("gr_rel_free_after", int'(free_cnt), 3);
    tick();
    beat(1, 128'hB2, 0);
    drive(1, 0, '0, 1, 1, 128'hB3, 0, 0);
    tick();
    idle(0);
    chk("post_rst_vld", int'(out_vld), 0);
    chk("post_rst_free", int'(free_cnt), EN);
    chk("post_rst_err", int'(err_pulse), 0);
    tick();
    idle(0);
    chk("post_rst_vld2", int'(out_vld), 0);
    tick();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      int fl[$];
      int id;
      bit r;
      r = ($urandom_range(0, 799) == 0);
      fl = {};
      for (int i = 0; i < EN; i++) if (m_st[i] == S_FILL) fl.push_back(i);
      if (fl.size() > 0 && $urandom_range(0, 99) < 85) id = fl[$urandom_range(0, fl.size() - 1)];
      else id = int'($urandom_range(0, EN - 1));
      drive(r, $urandom_range(0, 2) == 0, MW'($urandom), $urandom_range(0, 3) != 0, id,
            {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 9) == 0,
            $urandom_range(0, 2) != 0);
      tick();
    end
    idle(0);
    tick();
    chk("sb_lines_drained", line_q.size(), 0);
    chk("sb_exp_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vc_lfdb_assembler.md
VC_LFDB_ASSEMBLER -- requirements
Module: vc_lfdb_assembler

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 128, downstream beat width in bits.
REQ-002 SHALL have parameter DS_N, default 4, beats per cache line, >=2.
REQ-003 SHALL have parameter ENTRY_NUM, default 32, number of line-fill buffer entries, >=2.
REQ-004 SHALL have parameter META_W, default 16, per-entry sideband/metadata width.
REQ-005 SHALL have ports, clock and reset first:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- alloc_req  in  1  request a free entry
- alloc_meta  in  META_W  metadata stored on grant
- alloc_gnt  out  1  grant, same cycle as alloc_req
- alloc_id  out  $clog2(ENTRY_NUM)  granted entry index
- in_vld  in  1  downstream beat valid; in_rdy is tied 1
- in_entry_id  in  $clog2(ENTRY_NUM)  target entry
- in_data  in  BUS_WIDTH  beat data
- in_last  in  1  final beat of line
- out_vld  out  1  a complete line is presented
- out_rdy  in  1  consumer accepts line
- out_entry_id  out  $clog2(ENTRY_NUM)  presented entry
- out_data  out  BUS_WIDTH*DS_N  beat 0 in LSBs
- out_meta  out  META_W  stored metadata
- free_cnt  out  $clog2(ENTRY_NUM+1)  number of FREE entries
- err_pulse  out  1  one-cycle protocol-error flag

Function
REQ-006 Each entry SHALL hold state FREE, FILL or FULL, a beat counter of width $clog2(DS_N), metadata and DS_N beat slots.
REQ-007 alloc_gnt SHALL be alloc_req AND (free_cnt!=0), combinational. alloc_id SHALL be the lowest-index FREE entry.
REQ-008 On grant, the entry SHALL move FREE->FILL, beat counter 0, and metadata captured, all on the next edge.
REQ-009 A beat with in_vld=1 to a FILL entry SHALL be written into slot[beat counter], and the counter SHALL increment.
REQ-010 The entry SHALL move FILL->FULL on a beat where in_last=1 or counter==DS_N-1, whichever comes first. Unwritten slots keep stale contents.
REQ-011 err_pulse SHALL assert for exactly the cycle after an accepted beat with in_last != (counter==DS_N-1).
REQ-012 A beat to a FREE or FULL entry SHALL be dropped, with no state change, and SHALL raise err_pulse on the next cycle.
REQ-013 The output arbiter SHALL select among FULL entries round-robin, starting at rr_ptr. rr_ptr SHALL be set to (released index + 1) mod ENTRY_NUM on each release.
REQ-014 out_vld SHALL be 1 if any entry is FULL. out_entry_id, out_data and out_meta SHALL be the selected entry's contents, combinational from registers.
REQ-015 Latency: a last beat accepted at edge N SHALL give out_vld=1 in cycle N+1 if no other entry is FULL.
REQ-016 On out_vld AND out_rdy, the selected entry SHALL go FULL->FREE at the next edge. The selection SHALL stay stable while out_vld=1 and out_rdy=0.
REQ-017 An entry released in cycle N SHALL NOT be grantable until cycle N+1; there is no same-cycle bypass.
REQ-018 free_cnt SHALL equal the count of FREE entries, registered. It SHALL update by +1 on a release, -1 on a grant, and 0 when both occur in the same cycle.
REQ-019 A beat and a release on different entries in the same cycle SHALL both take effect. A beat to the entry being released is dropped per REQ-012.

Reset
REQ-020 While rst=1 at an edge, the block SHALL set all entries FREE, beat counters 0, rr_ptr 0, free_cnt=ENTRY_NUM and err_pulse 0.
REQ-021 In the cycle after reset, outputs SHALL be: out_vld 0, alloc_gnt equal to alloc_req.
REQ-022 Beat data and metadata storage SHALL NOT be reset.
REQ-023 Reset asserted mid-fill SHALL abandon all partial lines; no out_vld SHALL appear for them after reset.

Verification
REQ-024 Basic line fill with defaults:
- alloc -> id 0, meta 0x00AA.
- 4 beats 0x1..0x4, last on beat 4.
- Required response: out_vld the next cycle; out_data = {0x4,0x3,0x2,0x1}; out_meta 0x00AA; err_pulse never asserted.
REQ-025 Early last and bad target:
- in_last on beat 2 of entry 0: entry goes FULL, err_pulse=1 for one cycle.
- Beat to FREE entry 5: dropped, err_pulse=1, free_cnt unchanged.
REQ-026 Full buffer:
- 32 grants: free_cnt counts down to 0; the 33rd alloc_req sees alloc_gnt=0.
- Release entry 7: free_cnt=1 next cycle; the next grant returns id 7.
REQ-027 Round-robin and backpressure:
- Entries 2, 9 and 20 FULL, rr_ptr=10, out_rdy=0 for 3 cycles: out_entry_id stays 20.
- Then accept continuously: drain order 20, 2, 9.
REQ-028 Simultaneous events and reset:
- Grant and release in the same cycle: free_cnt unchanged.
- rst during beat 3 of entry 1: post-reset out_vld=0, free_cnt=32.
